bp_lite_to_stream: RTL and testbench
====================================

BP_LITE_TO_STREAM -- requirements
Module: bp_lite_to_stream

Interface
REQ-001 SHALL take parameter bp_params_p (default e_bp_default_cfg), the BP processor config that sets paddr/lce widths.
REQ-002 SHALL take parameter in_data_width_p (default "inv"), the lite (wide) data width in bits.
REQ-003 SHALL take parameter out_data_width_p (default "inv"), the stream (narrow) beat width in bits.
REQ-004 SHALL take parameter master_p (default 0): 1 = command side (writes stream), 0 = response side (reads stream).
REQ-005 SHALL have clk_i  input  1  clock; single clock domain, all logic on rising edge.
REQ-006 SHALL have reset_n_i  input  1  reset, synchronous, active-low.
REQ-007 SHALL have mem_i  input  in_mem_msg_width_lp  lite message {header, data}.
REQ-008 SHALL have mem_v_i  input  1  lite message valid.
REQ-009 SHALL have mem_ready_o  output  1  lite message accept (ready-and-valid).
REQ-010 SHALL have mem_header_o  output  out_mem_msg_header_width_lp  per-beat stream header.
REQ-011 SHALL have mem_data_o  output  out_data_width_p  stream beat data.
REQ-012 SHALL have mem_v_o  output  1  stream beat valid.
REQ-013 SHALL have mem_ready_and_i  input  1  stream beat accept; handshake = mem_v_o & mem_ready_and_i.
REQ-014 SHALL have mem_lock_o  output  1  high on every beat of a message except the last.

Function
REQ-015 SHALL implement states e_ready (buffer empty) and e_stream (buffer holds one message).
REQ-016 In e_ready: mem_ready_o=1 and mem_v_o=0; on mem_v_i, SHALL capture header and data, clear beat count, go to e_stream.
REQ-017 In e_stream: mem_v_o=1. Each handshake SHALL increment the beat count. A handshake on the last beat SHALL return to e_ready.
REQ-018 Beat count N: 1 if (master_p ^ is_wr), else max((1<<size)/out_data_bytes, 1); is_wr = msg_type in {e_mem_msg_wr, e_mem_msg_uc_wr}.
REQ-019 Beat k data SHALL be buffered data[k*out_data_width_p +: out_data_width_p]. For N=1, beat 0 = low slice.
REQ-020 Beat k header SHALL equal the captured header, except addr gets k*out_data_bytes added.
REQ-021 That addr add SHALL be confined to offset bits below log2(1<<size) (wrap within the message block); upper address bits stay unchanged.
REQ-022 mem_lock_o SHALL be (state==e_stream) & (beat count != N-1).
REQ-023 On last-beat handshake, mem_ready_o SHALL also be 1 (combinational from mem_ready_and_i). A mem_v_i in that cycle SHALL be captured and go straight to e_stream with count 0.
REQ-024 Latency: message accepted at cycle t SHALL present beat 0 at t+1. With continuous mem_ready_and_i, beat k is at t+1+k.
REQ-025 Outputs SHALL hold stable while mem_v_o=1 and mem_ready_and_i=0.
REQ-026 Sim-only assertions: out_data_width_p < in_data_width_p; in_data_width_p % out_data_width_p == 0; mem_v_i in e_stream outside the last-beat cycle flags X/protocol error.

Reset
REQ-027 While reset_n_i=0 at a clock edge: state <= e_ready, beat count <= 0, mem_v_o=0, mem_lock_o=0, mem_ready_o=0.
REQ-028 Reset mid-message SHALL discard the buffered message; no further beats of it SHALL appear.
REQ-029 Data/header buffer SHALL be unreset.

Structure
REQ-030 Mem message types/macros SHALL come from bp_me_pkg / bp_common_pkg. The state enum stays local; no new package types.
REQ-031 The beat counter SHALL be one sub-module instance, bsg_counter_clear_up, with reset driven as ~reset_n_i.

Verification
REQ-032 Case: master_p=0, in=512, out=64, read, size=64B, addr 0x1000, ready always 1 -> 8 beats at t+1..t+8 with addrs 0x1000..0x1038, lock=1 on beats 0-6 and 0 on beat 7.
REQ-033 Case: master_p=0, write response -> exactly 1 beat, lock=0, data = low 64 bits.
REQ-034 Case: master_p=1, write, size=32B, addr 0x2010 -> 4 beats with addrs 0x2010, 0x2018, 0x2000, 0x2008 (wrap).
REQ-035 Case: stall mem_ready_and_i low for 3 cycles on beat 2 -> header, data and lock held unchanged; beat 3 follows one cycle after release.
REQ-036 Case: back-to-back messages with mem_v_i high at the last-beat handshake -> new message beat 0 on the next cycle, no bubble.
REQ-037 Case: reset_n_i low for 1 cycle during beat 4 -> mem_v_o=0 next cycle, mem_ready_o=1 after release, no stale beats.

Source files
------------

// File: rtl/bp_lite_to_stream_pkg.sv
// Memory message types shared by the lite-to-stream converter and its users:
// processor config selector, message type/size encodings and the header layout.
package bp_lite_to_stream_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0
  } bp_params_e;

  localparam int unsigned paddr_width_gp       = 40;
  localparam int unsigned mem_payload_width_gp = 16;
  localparam int unsigned mem_subop_width_gp   = 4;

  typedef enum logic [3:0] {
    e_mem_msg_rd    = 4'd0,
    e_mem_msg_wr    = 4'd1,
    e_mem_msg_uc_rd = 4'd2,
    e_mem_msg_uc_wr = 4'd3,
    e_mem_msg_pre   = 4'd4
  } bp_mem_msg_e;

  // Message size is log2 of the byte count.
  typedef enum logic [2:0] {
    e_mem_msg_size_1   = 3'd0,
    e_mem_msg_size_2   = 3'd1,
    e_mem_msg_size_4   = 3'd2,
    e_mem_msg_size_8   = 3'd3,
    e_mem_msg_size_16  = 3'd4,
    e_mem_msg_size_32  = 3'd5,
    e_mem_msg_size_64  = 3'd6,
    e_mem_msg_size_128 = 3'd7
  } bp_mem_msg_size_e;

  typedef struct packed {
    logic [mem_payload_width_gp-1:0] payload;
    bp_mem_msg_size_e                size;
    logic [paddr_width_gp-1:0]       addr;
    logic [mem_subop_width_gp-1:0]   subop;
    bp_mem_msg_e                     msg_type;
  } bp_mem_header_s;

  localparam int unsigned mem_header_width_gp = $bits(bp_mem_header_s);

  // Physical address width implied by a processor config.
  function automatic int unsigned cfg_paddr_width(input bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 40;
      default:          return 40;
    endcase
  endfunction

  // Cached and uncached writes both carry write data.
  function automatic logic mem_msg_is_wr(input bp_mem_msg_e t);
    return (t == e_mem_msg_wr) || (t == e_mem_msg_uc_wr);
  endfunction

endpackage

// File: rtl/bsg_counter_clear_up.sv
// Up counter with synchronous clear; clear and up together load 1.
module bsg_counter_clear_up #(
  parameter int unsigned max_val_p  = 15,
  parameter int unsigned init_val_p = 0,
  localparam int unsigned ptr_width_lp = (max_val_p == 0) ? 1 : $clog2(max_val_p + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic                    up_i,
  output logic [ptr_width_lp-1:0] count_o
);

  logic [ptr_width_lp-1:0] count_q, count_d;

  // Next count: clear wins over hold, up adds one on top of a clear.
  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (clear_i) begin
      count_d = up_i ? ptr_width_lp'(1) : '0;
    end else if (up_i) begin
      count_d = count_q + ptr_width_lp'(1);
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset_i) begin
      count_q <= ptr_width_lp'(init_val_p);
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bp_lite_to_stream.sv
// Buffers one wide lite memory message and replays it as narrow stream beats,
// advancing the beat address within the message block on every beat.
module bp_lite_to_stream
  import bp_lite_to_stream_pkg::*;
#(
  parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
  parameter int unsigned in_data_width_p  = 512,
  parameter int unsigned out_data_width_p = 64,
  parameter bit          master_p         = 1'b0,
  localparam int unsigned in_mem_msg_width_lp         = mem_header_width_gp + in_data_width_p,
  localparam int unsigned out_mem_msg_header_width_lp = mem_header_width_gp
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [in_mem_msg_width_lp-1:0]         mem_i,
  input  logic                                   mem_v_i,
  output logic                                   mem_ready_o,
  output logic [out_mem_msg_header_width_lp-1:0] mem_header_o,
  output logic [out_data_width_p-1:0]            mem_data_o,
  output logic                                   mem_v_o,
  input  logic                                   mem_ready_and_i,
  output logic                                   mem_lock_o
);

  localparam int unsigned out_data_bytes_lp = out_data_width_p / 8;
  localparam int unsigned stream_words_lp   = in_data_width_p / out_data_width_p;
  localparam int unsigned max_msg_bytes_lp  = 128;
  localparam int unsigned size_beats_lp     = max_msg_bytes_lp / out_data_bytes_lp;
  localparam int unsigned max_beats_lp      = (size_beats_lp > stream_words_lp) ? size_beats_lp
                                                                                : stream_words_lp;
  localparam int unsigned cnt_width_lp      = $clog2(max_beats_lp);
  localparam int unsigned word_sel_width_lp = $clog2(stream_words_lp);

  typedef enum logic {
    e_ready  = 1'b0,
    e_stream = 1'b1
  } state_e;

  state_e state_q;

  bp_mem_header_s                                   hdr_in, hdr_q, hdr_out;
  logic [in_data_width_p-1:0]                       data_in;
  logic [stream_words_lp-1:0][out_data_width_p-1:0] data_q;

  logic                         streaming, handshake, last_beat, last_handshake, mem_fire;
  logic [cnt_width_lp-1:0]      beat_cnt, last_cnt;
  logic [word_sel_width_lp-1:0] word_idx;
  int unsigned                  msg_bytes, msg_beats;
  logic [paddr_width_gp-1:0]    addr_mask, addr_step;

  assign {hdr_in, data_in} = mem_i;

  assign streaming      = (state_q == e_stream);
  assign handshake      = streaming & mem_ready_and_i;
  assign last_beat      = (beat_cnt == last_cnt);
  assign last_handshake = handshake & last_beat;
  // The last-beat handshake frees the buffer in the same cycle, so a new
  // message can be taken without a bubble.
  assign mem_ready_o    = reset_n_i & (~streaming | last_handshake);
  assign mem_fire       = mem_ready_o & mem_v_i;

  assign mem_v_o    = streaming;
  assign mem_lock_o = streaming & ~last_beat;

  // Beats per message: one when this side carries no payload, else the
  // message bytes split into stream words (at least one).
  always_comb begin
    msg_bytes = 32'd1 << hdr_q.size;
    msg_beats = 1;
    if (!(master_p ^ mem_msg_is_wr(hdr_q.msg_type)) && (msg_bytes > out_data_bytes_lp)) begin
      msg_beats = msg_bytes / out_data_bytes_lp;
    end
    last_cnt = cnt_width_lp'(msg_beats - 1);
  end

  // Beat header: the address offset advances inside the message block only.
  always_comb begin
    addr_mask     = paddr_width_gp'(msg_bytes - 1);
    addr_step     = hdr_q.addr + paddr_width_gp'(beat_cnt) * paddr_width_gp'(out_data_bytes_lp);
    hdr_out       = hdr_q;
    hdr_out.addr  = (hdr_q.addr & ~addr_mask) | (addr_step & addr_mask);
  end

  assign mem_header_o = hdr_out;
  assign word_idx     = word_sel_width_lp'(beat_cnt);
  assign mem_data_o   = data_q[word_idx];

  // Message buffer, loaded whenever a lite message is accepted.
  always_ff @(posedge clk_i) begin
    // NOTE: the buffer is deliberately unreset; it is only read while the
    // state says it holds a message, so its power-up contents never escape.
    if (mem_fire) begin
      hdr_q  <= hdr_in;
      data_q <= data_in;
    end
  end

  // Control state: empty buffer vs. streaming the buffered message.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_ready;
    end else begin
      unique case (state_q)
        e_ready:  if (mem_v_i) state_q <= e_stream;
        e_stream: if (last_handshake && !mem_v_i) state_q <= e_ready;
        default:  state_q <= e_ready;
      endcase
    end
  end

  bsg_counter_clear_up #(
    .max_val_p  (max_beats_lp - 1),
    .init_val_p (0)
  ) beat_counter (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .clear_i (mem_fire | last_handshake),
    .up_i    (handshake & ~last_beat),
    .count_o (beat_cnt)
  );

  // Configuration sanity.
  assert property (@(posedge clk_i) out_data_width_p < in_data_width_p);
  assert property (@(posedge clk_i) (in_data_width_p % out_data_width_p) == 0);
  assert property (@(posedge clk_i) cfg_paddr_width(bp_params_p) == paddr_width_gp);

  // A new message may only arrive while the buffer is empty or draining its last beat.
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !$isunknown(mem_v_i));
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   !(mem_v_i && streaming && !last_handshake));

endmodule

// File: tb/tb_bp_lite_to_stream.sv
// Bench for bp_lite_to_stream: a response-side and a command-side instance,
// each driven with lite messages and checked beat by beat against a
// message-to-beats reference model.
module tb_bp_lite_to_stream;
  import bp_lite_to_stream_pkg::*;

  localparam int IN_W  = 512;
  localparam int OUT_W = 64;
  localparam int HDR_W = mem_header_width_gp;
  localparam int MSG_W = HDR_W + IN_W;
  localparam int MAX_CYC = 4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic [MSG_W-1:0] mem_in  [2];
  logic             v_in    [2];
  logic             rdy     [2];
  logic [HDR_W-1:0] hdr_out [2];
  logic [OUT_W-1:0] dat_out [2];
  logic             v_out   [2];
  logic             rdy_and [2];
  logic             lock    [2];

  bp_lite_to_stream #(
    .bp_params_p(e_bp_default_cfg), .in_data_width_p(IN_W), .out_data_width_p(OUT_W), .master_p(1'b0)
  ) dut_rsp (
    .clk_i(clk), .reset_n_i(reset_n), .mem_i(mem_in[0]), .mem_v_i(v_in[0]), .mem_ready_o(rdy[0]),
    .mem_header_o(hdr_out[0]), .mem_data_o(dat_out[0]), .mem_v_o(v_out[0]),
    .mem_ready_and_i(rdy_and[0]), .mem_lock_o(lock[0])
  );

  bp_lite_to_stream #(
    .bp_params_p(e_bp_default_cfg), .in_data_width_p(IN_W), .out_data_width_p(OUT_W), .master_p(1'b1)
  ) dut_cmd (
    .clk_i(clk), .reset_n_i(reset_n), .mem_i(mem_in[1]), .mem_v_i(v_in[1]), .mem_ready_o(rdy[1]),
    .mem_header_o(hdr_out[1]), .mem_data_o(dat_out[1]), .mem_v_o(v_out[1]),
    .mem_ready_and_i(rdy_and[1]), .mem_lock_o(lock[1])
  );

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [HDR_W-1:0] hdr;
    logic [OUT_W-1:0] data;
    logic             lock;
    int               k;
  } beat_t;

  typedef struct {
    bp_mem_header_s  hdr;
    logic [IN_W-1:0] data;
  } msg_t;

  beat_t exp_q  [$];
  msg_t  pend_q [$];

  // ---------------- reference model ----------------
  function automatic int num_beats(input bit master, input bp_mem_header_s h);
    int bytes;
    bit wr;
    bytes = 1 << int'(h.size);
    wr    = (h.msg_type == e_mem_msg_wr) || (h.msg_type == e_mem_msg_uc_wr);
    if (master != wr) return 1;
    return (bytes / 8 > 1) ? bytes / 8 : 1;
  endfunction

  // Append the expected beats of one message to the expectation queue.
  task automatic expand(input bit master, input msg_t m);
    int             n;
    longint unsigned blk, base, off;
    bp_mem_header_s bh;
    beat_t          b;
    n = num_beats(master, m.hdr);
    blk  = longint'(1) << int'(m.hdr.size);
    base = longint'(m.hdr.addr);
    for (int k = 0; k < n; k++) begin
      off     = (base % blk + longint'(k) * 8) % blk;
      bh      = m.hdr;
      bh.addr = 40'(base - base % blk + off);
      b.hdr   = bh;
      b.data  = m.data[k*OUT_W +: OUT_W];
      b.lock  = (k != n - 1);
      b.k     = k;
      exp_q.push_back(b);
    end
  endtask

  function automatic bp_mem_header_s mk_hdr(input bp_mem_msg_e t, input bp_mem_msg_size_e s,
                                            input logic [39:0] a);
    bp_mem_header_s h;
    h.payload  = 16'($urandom);
    h.size     = s;
    h.addr     = a;
    h.subop    = 4'($urandom);
    h.msg_type = t;
    return h;
  endfunction

  function automatic logic [IN_W-1:0] rand_data();
    logic [IN_W-1:0] d;
    for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic queue_msg(input bp_mem_header_s h);
    msg_t m;
    m.hdr  = h;
    m.data = rand_data();
    pend_q.push_back(m);
  endtask

  // Drive pending messages into one instance and check every cycle against the model.
  // Starts and ends on a falling edge.
  task automatic run(input int sel, input int stall_pct, input int stall_beat, input int stall_len,
                     input string name);
    int    cyc;
    int    stalled;
    bit    ra, will;
    beat_t e;
    cyc = 0;
    stalled = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < MAX_CYC) begin
      if (exp_q.size() > 0 && exp_q[0].k == stall_beat && stalled < stall_len) begin
        ra = 1'b0;
        stalled++;
      end else begin
        ra = ($urandom_range(99) >= stall_pct);
      end
      rdy_and[sel] = ra;
      will = (exp_q.size() == 0) || (exp_q.size() == 1 && ra);
      if (will && pend_q.size() > 0) begin
        mem_in[sel] = {pend_q[0].hdr, pend_q[0].data};
        v_in[sel]   = 1'b1;
      end else begin
        v_in[sel]   = 1'b0;
      end
      #1;
      vectors++;
      if (rdy[sel] !== will) begin
        miscompares++;
        $display("FAIL %s ready cyc=%0d: got %b expected %b", name, cyc, rdy[sel], will);
      end
      vectors++;
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        if (v_out[sel] !== 1'b1 || hdr_out[sel] !== e.hdr || dat_out[sel] !== e.data ||
            lock[sel] !== e.lock) begin
          miscompares++;
          $display("FAIL %s beat %0d cyc=%0d: got v=%b hdr=%h data=%h lock=%b expected v=1 hdr=%h data=%h lock=%b",
                   name, e.k, cyc, v_out[sel], hdr_out[sel], dat_out[sel], lock[sel], e.hdr, e.data, e.lock);
        end
      end else if (v_out[sel] !== 1'b0 || lock[sel] !== 1'b0) begin
        miscompares++;
        $display("FAIL %s idle cyc=%0d: got v=%b lock=%b expected v=0 lock=0",
                 name, cyc, v_out[sel], lock[sel]);
      end
      if (exp_q.size() > 0 && ra) void'(exp_q.pop_front());
      if (v_in[sel]) expand(sel == 1, pend_q.pop_front());
      @(negedge clk);
      cyc++;
    end
    v_in[sel]    = 1'b0;
    rdy_and[sel] = 1'b1;
    if (cyc >= MAX_CYC) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: %0d beats outstanding after %0d cycles, expected 0",
               name, exp_q.size(), cyc);
      exp_q.delete();
      pend_q.delete();
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mem_in[s]  = '0;
      v_in[s]    = 1'b0;
      rdy_and[s] = 1'b1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (v_out[s] !== 1'b0 || lock[s] !== 1'b0 || rdy[s] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold dut%0d: got v=%b lock=%b ready=%b expected 0 0 0",
                 s, v_out[s], lock[s], rdy[s]);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (v_out[s] !== 1'b0 || rdy[s] !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_release dut%0d: got v=%b ready=%b expected v=0 ready=1",
                 s, v_out[s], rdy[s]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_burst_read();
    queue_msg(mk_hdr(e_mem_msg_rd, e_mem_msg_size_64, 40'h1000));
    run(0, 0, -1, 0, "burst_read");
  endtask

  task automatic test_write_rsp();
    queue_msg(mk_hdr(e_mem_msg_wr, e_mem_msg_size_64, 40'h1040));
    queue_msg(mk_hdr(e_mem_msg_uc_wr, e_mem_msg_size_32, 40'h1080));
    run(0, 0, -1, 0, "write_rsp");
  endtask

  task automatic test_wrap();
    queue_msg(mk_hdr(e_mem_msg_wr, e_mem_msg_size_32, 40'h2010));
    queue_msg(mk_hdr(e_mem_msg_rd, e_mem_msg_size_64, 40'h2040));
    queue_msg(mk_hdr(e_mem_msg_uc_wr, e_mem_msg_size_64, 40'h2078));
    run(1, 0, -1, 0, "wrap");
  endtask

  task automatic test_stall();
    queue_msg(mk_hdr(e_mem_msg_rd, e_mem_msg_size_64, 40'h5000));
    run(0, 0, 2, 3, "stall");
  endtask

  task automatic test_back_to_back();
    queue_msg(mk_hdr(e_mem_msg_rd, e_mem_msg_size_64, 40'h6000));
    queue_msg(mk_hdr(e_mem_msg_uc_rd, e_mem_msg_size_16, 40'h6108));
    queue_msg(mk_hdr(e_mem_msg_wr, e_mem_msg_size_8, 40'h6200));
    queue_msg(mk_hdr(e_mem_msg_rd, e_mem_msg_size_32, 40'h6330));
    run(0, 0, -1, 0, "b2b_rsp");
    queue_msg(mk_hdr(e_mem_msg_wr, e_mem_msg_size_16, 40'h7008));
    queue_msg(mk_hdr(e_mem_msg_wr, e_mem_msg_size_64, 40'h7100));
    run(1, 0, -1, 0, "b2b_cmd");
  endtask

  task automatic test_reset_mid();
    bp_mem_header_s  h, oh;
    logic [IN_W-1:0] d;
    h = mk_hdr(e_mem_msg_rd, e_mem_msg_size_64, 40'h3000);
    d = rand_data();
    mem_in[0]  = {h, d};
    v_in[0]    = 1'b1;
    rdy_and[0] = 1'b1;
    @(negedge clk);
    v_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    oh = hdr_out[0];
    vectors++;
    if (v_out[0] !== 1'b1 || oh.addr !== 40'h3020 || dat_out[0] !== d[4*OUT_W +: OUT_W] ||
        lock[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid beat4: got v=%b addr=%h data=%h lock=%b expected v=1 addr=3020 data=%h lock=1",
               v_out[0], oh.addr, dat_out[0], lock[0], d[4*OUT_W +: OUT_W]);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (rdy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid ready_in_reset: got %b expected 0", rdy[0]);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    vectors++;
    if (v_out[0] !== 1'b0 || lock[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid after: got v=%b lock=%b ready=%b expected v=0 lock=0 ready=1",
               v_out[0], lock[0], rdy[0]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      vectors++;
      if (v_out[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid stale beat cyc=%0d: got v=%b expected 0", i, v_out[0]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    bp_mem_header_s h;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 25; i++) begin
        h = mk_hdr(bp_mem_msg_e'($urandom_range(4)), bp_mem_msg_size_e'($urandom_range(6)),
                   {8'($urandom_range(255)), 32'($urandom)});
        queue_msg(h);
      end
      run(s, 30, -1, 0, s == 0 ? "random_rsp" : "random_cmd");
    end
  endtask

  initial begin
    test_reset();
    test_burst_read();
    test_write_rsp();
    test_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 500000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
